flag_context_stack: RTL

//  Parametrised successor to the single-cycle flag latch.

---
 rtl/flag_context_stack.sv | 92 +++++++++
 1 files changed

// File: rtl/flag_context_stack.sv
// Live ALU status flags with per-bit write enables, plus a LIFO of saved flag contexts.
// Optional sticky Overflow/Underflow error bits are built only when FLAG_STACK_ERR_EN is defined.
module flag_context_stack #(
  parameter  int FLAG_WIDTH = 5,
  parameter  int DEPTH      = 4,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [FLAG_WIDTH-1:0] Flags,
  input  logic [FLAG_WIDTH-1:0] FlagWrEn,
  input  logic                  Push,
  input  logic                  Pop,
  input  logic                  ErrClear,
  output logic [FLAG_WIDTH-1:0] savedFlags,
  output logic [LVL_W-1:0]      Level,
  output logic                  Empty,
  output logic                  Full,
  output logic                  Overflow,
  output logic                  Underflow
);

  logic [FLAG_WIDTH-1:0] stack [DEPTH];
  logic [FLAG_WIDTH-1:0] top_val;
  logic [FLAG_WIDTH-1:0] upd_flags;
  logic [LVL_W-1:0]      top_lvl;
  logic                  do_push;
  logic                  do_pop;
  logic                  do_swap;
  logic                  ovf_evt;
  logic                  unf_evt;

  // Status decodes straight from the Level register, never from inputs.
  assign Empty = (Level == '0);
  assign Full  = (Level == LVL_W'(DEPTH));

  assign top_lvl   = Level - LVL_W'(1);
  assign upd_flags = (savedFlags & ~FlagWrEn) | (Flags & FlagWrEn);

  // A Pop on an empty stack drops any simultaneous Push as well.
  assign do_push = Push && !Pop && !Full;
  assign do_pop  = Pop && !Push && !Empty;
  assign do_swap = Push && Pop && !Empty;
  assign ovf_evt = Push && !Pop && Full;
  assign unf_evt = Pop && Empty;

  always_comb begin
    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_lvl == LVL_W'(i)) top_val = stack[i];
    end
  end

  // Register stage: flags, stack entries and level all update on the same edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      savedFlags <= '0;
      Level      <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      if (do_pop || do_swap) savedFlags <= top_val;
      else                   savedFlags <= upd_flags;

      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (Level == LVL_W'(i)))   stack[i] <= savedFlags;
        if (do_swap && (top_lvl == LVL_W'(i))) stack[i] <= savedFlags;
      end

      if (do_push)     Level <= Level + LVL_W'(1);
      else if (do_pop) Level <= Level - LVL_W'(1);
    end
  end

`ifdef FLAG_STACK_ERR_EN
  // A fresh error in the same cycle as ErrClear leaves the bit set.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Overflow  <= (Overflow  && !ErrClear) || ovf_evt;
      Underflow <= (Underflow && !ErrClear) || unf_evt;
    end
  end
`else
  logic unused_err;
  assign unused_err = ErrClear ^ ovf_evt ^ unf_evt;
  assign Overflow   = 1'b0;
  assign Underflow  = 1'b0;
`endif

endmodule
